// File: rtl/fb_scan_reader_if.sv
// Framebuffer read-port bundle: the scanner drives address/enable,
// the memory answers with one pixel bit a fixed number of cycles later.
interface fb_scan_reader_if #(
    parameter int ADDR_WIDTH = 19
);
    logic [ADDR_WIDTH-1:0] addrRD;
    logic                  rdEn;
    logic                  dataRD;

    modport master (output addrRD, output rdEn, input dataRD);
    modport slave  (input addrRD, input rdEn, output dataRD);
endinterface

// File: rtl/fb_scan_reader.sv
// Raster scanner for the 1-bit trace framebuffer: VGA timing, pipelined
// read addressing, realignment of returned pixels and scope-grid overlay.
module fb_scan_reader #(
    parameter int          ADDR_WIDTH  = 19,
    parameter int          WIDTH       = 640,
    parameter int          HEIGHT      = 480,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          RD_LAT      = 2,
    parameter int          GRID_X      = 80,
    parameter int          GRID_Y      = 60,
    parameter logic [11:0] TRACE_COLOR = 12'hFF0,
    parameter logic [11:0] GRID_COLOR  = 12'h444,
    parameter logic [11:0] BG_COLOR    = 12'h000
) (
    input  logic              clkRD,
    input  logic              rst,
    fb_scan_reader_if.master  fbRd,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              frameStart
);

    localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int GXW     = $clog2(GRID_X + 1);
    localparam int GYW     = $clog2(GRID_Y + 1);
    localparam int MW      = ADDR_WIDTH + 9;
    localparam int L       = 2 + RD_LAT;

    localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT      = HW'(WIDTH);
    localparam logic [HW-1:0]  H_ACT_LAST = HW'(WIDTH - 1);
    localparam logic [HW-1:0]  HS_START   = HW'(WIDTH + H_FP);
    localparam logic [HW-1:0]  HS_END     = HW'(WIDTH + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT      = VW'(HEIGHT);
    localparam logic [VW-1:0]  V_ACT_LAST = VW'(HEIGHT - 1);
    localparam logic [VW-1:0]  VS_START   = VW'(HEIGHT + V_FP);
    localparam logic [VW-1:0]  VS_END     = VW'(HEIGHT + V_FP + V_SYNC);
    localparam logic [GXW-1:0] GX_LAST    = GXW'(GRID_X - 1);
    localparam logic [GYW-1:0] GY_LAST    = GYW'(GRID_Y - 1);

    // Flag bundle carried down the delay line: {first, grid, active, vs_n, hs_n}.
    localparam logic [4:0] FLAGS_RESET = 5'b00011;

    logic [HW-1:0]  hCnt;
    logic [VW-1:0]  vCnt;
    logic [GXW-1:0] gx;
    logic [GYW-1:0] gy;

    logic           active0;
    logic           hsN0;
    logic           vsN0;
    logic           grid0;
    logic           first0;
    logic [4:0]     flags0;

    logic [MW-1:0]         rowMul;
    logic [HW-1:0]         col1;
    logic                  active1;
    logic [MW-1:0]         addrSum;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic                  rdEnReg;

    logic [4:0]     flagsL;

    // Timing counters; gx/gy track position within the grid cell so no modulo is needed.
    always_ff @(posedge clkRD) begin
        if (rst) begin
            hCnt <= '0;
            vCnt <= '0;
            gx   <= '0;
            gy   <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            gx   <= '0;
            if (vCnt == V_LAST) begin
                vCnt <= '0;
                gy   <= '0;
            end else begin
                vCnt <= vCnt + 1'b1;
                gy   <= (gy == GY_LAST) ? '0 : gy + 1'b1;
            end
        end else begin
            hCnt <= hCnt + 1'b1;
            gx   <= (gx == GX_LAST) ? '0 : gx + 1'b1;
        end
    end

    always_comb begin
        active0 = (hCnt < H_ACT) && (vCnt < V_ACT);
        hsN0    = !((hCnt >= HS_START) && (hCnt < HS_END));
        vsN0    = !((vCnt >= VS_START) && (vCnt < VS_END));
        grid0   = active0 && ((gx == '0) || (hCnt == H_ACT_LAST) ||
                              (gy == '0) || (vCnt == V_ACT_LAST));
        first0  = (hCnt == '0) && (vCnt == '0);
        flags0  = {first0, grid0, active0, vsN0, hsN0};
    end

    // Address stage 1: multiply once per pixel, carry column and active alongside.
    always_ff @(posedge clkRD) begin
        if (rst) begin
            rowMul  <= '0;
            col1    <= '0;
            active1 <= 1'b0;
        end else begin
            rowMul  <= MW'(vCnt) * MW'(WIDTH);
            col1    <= hCnt;
            active1 <= active0;
        end
    end

    assign addrSum = rowMul + MW'(col1);

    always_ff @(posedge clkRD) begin
        if (rst) begin
            addrReg <= '0;
            rdEnReg <= 1'b0;
        end else begin
            addrReg <= active1 ? addrSum[ADDR_WIDTH-1:0] : '0;
            rdEnReg <= active1;
        end
    end

    assign fbRd.addrRD = addrReg;
    assign fbRd.rdEn   = rdEnReg;

    // Flag delay line matches address pipeline plus memory latency.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_dly
            logic [4:0] q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clkRD) begin
                    if (rst) q <= FLAGS_RESET;
                    else     q <= flags0;
                end
            end else begin : g_tail
                always_ff @(posedge clkRD) begin
                    if (rst) q <= FLAGS_RESET;
                    else     q <= g_dly[gi-1].q;
                end
            end
        end
    endgenerate

    assign flagsL = g_dly[L-1].q;

    // dataRD only matters while the aligned active flag is set, so memory X in blanking is masked.
    always_ff @(posedge clkRD) begin
        if (rst) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            rgb        <= 12'h000;
            frameStart <= 1'b0;
        end else begin
            hsync      <= flagsL[0];
            vsync      <= flagsL[1];
            de         <= flagsL[2];
            frameStart <= flagsL[4] && flagsL[2];
            if (!flagsL[2])
                rgb <= 12'h000;
            else if (fbRd.dataRD === 1'b1)
                rgb <= TRACE_COLOR;
            else if (flagsL[3])
                rgb <= GRID_COLOR;
            else
                rgb <= BG_COLOR;
        end
    end

endmodule

// File: doc/fb_scan_reader.md
Name: fb_scan_reader

Overview:
- Read-side counterpart of the sample-to-address write pipeline. It scans the 640x480 one-bit trace framebuffer in raster order and generates VGA timing.
- Issues pipelined read addresses (row*WIDTH + col) to the framebuffer's read port, realigns returned pixel bits with delayed sync/DE, overlays the scope grid, and drives 12-bit RGB.
- Sits between the dual-port framebuffer read port and the VGA pins.

Parameters:
- ADDR_WIDTH, 19, framebuffer address width.
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- H_FP, 16, horizontal front porch (px).
- H_SYNC, 96, hsync pulse width (px).
- H_BP, 48, horizontal back porch (px).
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- RD_LAT, 2, framebuffer read latency in cycles (addrRD/rdEn to dataRD), >=1.
- GRID_X, 80, grid column spacing (px).
- GRID_Y, 60, grid row spacing (lines).
- TRACE_COLOR, 12'hFF0, RGB444 for set pixels.
- GRID_COLOR, 12'h444, RGB444 for grid.
- BG_COLOR, 12'h000, RGB444 background.

Ports:
- clkRD  in  1  pixel clock (25 MHz nominal).
- rst  in  1  synchronous, active-high reset.
- addrRD  out  ADDR_WIDTH  framebuffer read address.
- rdEn  out  1  read enable, high only for active-area addresses.
- dataRD  in  1  framebuffer pixel bit, valid RD_LAT cycles after its addrRD/rdEn.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- de  out  1  active-video qualifier.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}.
- frameStart  out  1  one-cycle pulse aligned with the first active pixel of the frame at the outputs.

Behaviour:
- One clock (clkRD); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: addrRD=0, rdEn=0, hsync=1, vsync=1, de=0, rgb=0, frameStart=0. All counters and delay-line stages are cleared.
- rst asserted mid-frame: the next cycle shows reset values and the scan restarts at (0,0). There is no partial-line recovery.
- Timing counters:
  - hCnt runs 0..H_TOTAL-1, with H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP = 800.
  - vCnt runs 0..V_TOTAL-1 (525). It increments when hCnt wraps to 0 and wraps to 0 itself after 524.
- Stage 0 (cycle t) flags:
  - active = hCnt<WIDTH && vCnt<HEIGHT.
  - hs_n = 0 iff WIDTH+H_FP <= hCnt < WIDTH+H_FP+H_SYNC, i.e. 656..751.
  - vs_n = 0 iff HEIGHT+V_FP <= vCnt < HEIGHT+V_FP+V_SYNC, i.e. 490..491.
- Address pipeline:
  - Stage 1 registers rowMul = vCnt*WIDTH (ADDR_WIDTH+9 bits internally) plus the delayed col and active flag.
  - Stage 2 registers addrRD = rowMul+col, truncated to ADDR_WIDTH, and rdEn = active.
  - addrRD therefore appears at t+2. When inactive, addrRD=0 and rdEn=0.
- Grid: sub-counters gx and gy replace modulo.
  - gx resets at hCnt=0 and wraps at GRID_X-1. gy resets at vCnt=0, advances per line, and wraps at GRID_Y-1.
  - grid = active && (gx==0 || hCnt==WIDTH-1 || gy==0 || vCnt==HEIGHT-1).
- Alignment:
  - hs_n, vs_n, active and grid pass through a delay line of L = 2+RD_LAT stages.
  - Output registers update at t+L+1, sampling dataRD at t+L.
- Pixel priority:
  - de=0 gives rgb=BG_COLOR forced to 12'h000 (black in blanking).
  - Otherwise dataRD=1 gives TRACE_COLOR, then grid gives GRID_COLOR, else BG_COLOR.
- frameStart = 1 at the output cycle carrying (0,0) when de is high; 0 otherwise. Exactly one pulse per frame.
- dataRD is ignored when the delayed active flag is 0, so X from memory during blanking must not reach rgb.
- Total latency from the stage-0 counter value to the pins is 3+RD_LAT cycles: 5 with defaults.

Test Plan:
- Reset/startup: hold rst 3 cycles, then release.
  - addrRD=0, rdEn=0, hsync=vsync=1, de=0, rgb=0 during reset and for the first 4 cycles after release.
  - de rises on cycle 5 after release with frameStart=1.
- Address sequence, with a memory model of RD_LAT=2:
  - First active line gives addrRD 0,1,...,639 with rdEn=1, then rdEn=0 for 160 cycles.
  - Line 1 starts at 640.
  - Last active pixel (639,479) gives addrRD=307199.
- Sync timing over one full frame:
  - hsync low exactly 96 cycles per line, starting 656 cycles after de rise of that line.
  - vsync low exactly 2 lines.
  - 800 cycles per line, 420000 per frame, 480 de-high lines of 640.
- Data alignment: model returns 1 only for address 1000 (x=360,y=1).
  - rgb=12'hFF0 on exactly one de-high cycle, the 361st active pixel of line 1.
  - Neighbouring pixels show 12'h000.
  - Drive dataRD=1 continuously during blanking: rgb stays 0 and de stays 0.
- Grid:
  - With a zero framebuffer, pixels at x in {0,80,...,560,639} or y in {0,60,...,420,479} read 12'h444; all others 12'h000.
  - With dataRD=1 at (80,60), the output is 12'hFF0 (trace priority).
- Reset mid-frame: assert rst for 1 cycle at vCnt=200, hCnt=300.
  - Next cycle shows reset values.
  - Scan restarts at addrRD=0 two cycles after release, and the frameStart pulse recurs after the restart.
